// File: rtl/ecc_hamming_pkg.sv
// Shared types and widths for the (7,4)+overall-parity SECDED decode path.
// Combinational definitions only; no latency, no flow control.
package ecc_hamming_pkg;
   localparam int SYN_W  = 3;
   localparam int DATA_W = 4;
   localparam int CW_W   = 7;

   typedef enum logic [1:0] {
      ECC_OK     = 2'd0,
      ECC_CORR   = 2'd1,
      ECC_UNCORR = 2'd2
   } ecc_status_t;

   typedef struct packed {
      logic [CW_W-1:0]  codeword;
      logic [SYN_W-1:0] syndrome;
      logic             parity_err;
      ecc_status_t      status;
   } s1_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      ecc_status_t       status;
      logic [SYN_W-1:0]  syndrome;
      logic [CW_W-1:0]   codeword;
   } s2_t;

   // Data bits sit at Hamming positions 3,5,6,7.
   function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
      return {cw[6], cw[5], cw[4], cw[2]};
   endfunction
endpackage

// File: rtl/ecc_hamming_74_syndrome.sv
// Syndrome, overall-parity error and SECDED class for one (7,4)+parity word.
// Purely combinational: zero latency, no flow control.
module ecc_hamming_74_syndrome
   import ecc_hamming_pkg::*;
(
   input  logic [CW_W-1:0]  codeword,
   input  logic             extra_parity,
   output logic [SYN_W-1:0] syndrome,
   output logic             parity_err,
   output ecc_status_t      status
);
   assign syndrome[0] = codeword[0] ^ codeword[2] ^ codeword[4] ^ codeword[6];
   assign syndrome[1] = codeword[1] ^ codeword[2] ^ codeword[5] ^ codeword[6];
   assign syndrome[2] = codeword[3] ^ codeword[4] ^ codeword[5] ^ codeword[6];
   assign parity_err  = (^codeword) ^ extra_parity;

   // Odd overall parity means exactly one flip (possibly the parity bit itself).
   always_comb begin
      status = ECC_UNCORR;
      if (parity_err)
         status = ECC_CORR;
      else if (syndrome == '0)
         status = ECC_OK;
   end
endmodule

// File: rtl/ecc_hamming_74_decoder_pipe.sv
// Two-stage SECDED decoder with saturating error counters and a sticky error log.
// Latency 2 cycles; in_ready follows out_ready combinationally, output held under backpressure.
module ecc_hamming_74_decoder_pipe
   import ecc_hamming_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   in_codeword,
   input  logic              in_extra_parity,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_status,
   output logic [SYN_W-1:0]  out_syndrome,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt,
   input  logic              cnt_clr,
   output logic              log_valid,
   output logic [CW_W-1:0]   log_codeword,
   output logic [SYN_W-1:0]  log_syndrome,
   input  logic              log_clr
);
   logic             s1_valid, s2_valid;
   logic             s1_adv, s2_adv, deliver;
   s1_t              s1, s1_nxt;
   s2_t              s2;
   logic [CW_W-1:0]  flip_mask, corr_cw;

   ecc_hamming_74_syndrome u_syn (
      .codeword     (in_codeword),
      .extra_parity (in_extra_parity),
      .syndrome     (s1_nxt.syndrome),
      .parity_err   (s1_nxt.parity_err),
      .status       (s1_nxt.status)
   );
   assign s1_nxt.codeword = in_codeword;

   assign s2_adv   = !s2_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;
   assign deliver  = s2_valid && out_ready;

   // A zero syndrome with odd parity means only the parity bit flipped.
   always_comb begin
      flip_mask = '0;
      if (s1.parity_err && s1.syndrome != '0)
         flip_mask[s1.syndrome - 3'd1] = 1'b1;
      corr_cw = s1.codeword ^ flip_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s1       <= '0;
         s2       <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid)
               s1 <= s1_nxt;
         end
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2.data     <= extract_data(corr_cw);
               s2.status   <= s1.status;
               s2.syndrome <= s1.syndrome;
               s2.codeword <= s1.codeword;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (cnt_clr) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (deliver) begin
         if (s2.status == ECC_CORR && corr_cnt != '1)
            corr_cnt <= corr_cnt + CNT_W'(1);
         if (s2.status == ECC_UNCORR && uncorr_cnt != '1)
            uncorr_cnt <= uncorr_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         log_valid    <= 1'b0;
         log_codeword <= '0;
         log_syndrome <= '0;
      end else if (log_clr) begin
         log_valid    <= 1'b0;
         log_codeword <= '0;
         log_syndrome <= '0;
      end else if (deliver && s2.status == ECC_UNCORR && !log_valid) begin
         log_valid    <= 1'b1;
         log_codeword <= s2.codeword;
         log_syndrome <= s2.syndrome;
      end
   end

   assign out_valid    = s2_valid;
   assign out_data     = s2.data;
   assign out_status   = s2.status;
   assign out_syndrome = s2.syndrome;
endmodule

// File: doc/ecc_hamming_74_decoder_pipe.md
# ecc_hamming_74_decoder_pipe

Pipelined SECDED decoder for the (7,4) Hamming code plus overall parity bit. Sits directly downstream of the (7,4) encoder path (after storage/link): accepts the 7-bit codeword and extra parity bit, corrects single-bit errors, detects double-bit errors, and returns 4-bit data with status. Provides valid/ready flow control, saturating error counters and a sticky first-uncorrectable-error log for software.

## Interface
- CNT_W, 16, width of each saturating error counter
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  input word valid
- in_ready  out  1  decoder can accept a word
- in_codeword  in  7  codeword; bit i is Hamming position i+1
- in_extra_parity  in  1  overall even-parity bit over the codeword
- out_valid  out  1  decoded word valid
- out_ready  in  1  consumer accepts the word
- out_data  out  4  corrected data
- out_status  out  2  0 OK, 1 CORRECTED, 2 UNCORRECTABLE
- out_syndrome  out  3  raw syndrome of the word
- corr_cnt  out  CNT_W  count of CORRECTED words delivered
- uncorr_cnt  out  CNT_W  count of UNCORRECTABLE words delivered
- cnt_clr  in  1  synchronous clear of both counters
- log_valid  out  1  sticky: an UNCORRECTABLE word has been logged
- log_codeword  out  7  codeword of first logged uncorrectable word
- log_syndrome  out  3  its syndrome
- log_clr  in  1  synchronous clear of the log

## Operation
- Syndrome: s[0]=c0^c2^c4^c6, s[1]=c1^c2^c5^c6, s[2]=c3^c4^c5^c6; p = ^in_codeword ^ in_extra_parity.
- Classification: s=0,p=0 -> OK; s≠0,p=1 -> CORRECTED, flip codeword[s-1]; s=0,p=1 -> CORRECTED (extra parity bit flipped, codeword unchanged); s≠0,p=0 -> UNCORRECTABLE, data passed uncorrected.
- Data extract from (corrected) codeword: out_data = {c6,c5,c4,c2}.
- Stage 1 (S1): registers codeword, syndrome, p. Stage 2 (S2): registers corrected data, status, syndrome, raw codeword.
- Counters increment on out_valid&&out_ready per status; saturate at all-ones. cnt_clr wins over a same-cycle increment (that event is not counted).
- Log captures codeword/syndrome on first UNCORRECTABLE delivery (out_valid&&out_ready) while log_valid=0; later errors ignored. log_clr wins over same-cycle capture.

## Timing
- Reset: in_ready=1 after reset; out_valid=0, out_data=0, out_status=0, out_syndrome=0, counters 0, log_valid=0, log_codeword=0, log_syndrome=0; pipeline valids cleared.
- Latency: word accepted in cycle N appears on out_valid in cycle N+2 with no backpressure.
- Throughput one word/cycle. Each stage advances when its successor is empty or draining: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv.
- in_ready is combinational from out_ready (no skid buffer); no combinational path in_valid -> out_valid.
- Output held stable while out_valid=1 and out_ready=0.
- Reset asserted mid-stream: all in-flight words discarded, counters and log cleared.

## Structure
- Shared package ecc_hamming_pkg: status enum type (ECC_OK, ECC_CORR, ECC_UNCORR), syndrome width constant 3, data/codeword width constants 4/7.
- One combinational sub-module ecc_hamming_74_syndrome: codeword + extra parity in, syndrome, p, status class out; reusable by other decoders.

## Test plan
- Clean word: in_codeword=7'h55, extra=0 -> 2 cycles later out_data=4'hB, status OK, syndrome 0; counters unchanged.
- Single error: 7'h45 (bit 4 flipped), extra=0 -> out_data=4'hB, status CORRECTED, syndrome 5; corr_cnt=1.
- Parity-bit error: 7'h55, extra=1 -> out_data=4'hB, CORRECTED, syndrome 0.
- Double error: 7'h56 (bits 0,1 flipped), extra=0 -> UNCORRECTABLE, syndrome 3; uncorr_cnt=1, log_valid=1, log_codeword=7'h56; second double error leaves log unchanged; log_clr -> log_valid=0.
- Backpressure: stream 4 words with out_ready=0 -> in_ready drops after 2 accepted; out holds first word; releasing out_ready delivers all 4 in order, none lost/duplicated.
- Counter saturation/clear: CNT_W=2, 5 single errors -> corr_cnt=3; cnt_clr same cycle as a delivery -> 0.
